// File: rtl/ahb_matrix_pkg.sv
// Shared AHB-Lite encodings and helpers for the bus-matrix output stage.
// Optional build macro for the output stage: AHB_OUTSTAGE_FIXED_PRIO_EN.
package ahb_matrix_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Width of a port index; never zero so a 1-port build still has a legal vector.
    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb_matrix_outstage_rr_if.sv
// Bus bundle of one matrix output stage: flattened master-side ports in, one slave port out.
// Optional build macro for the output stage: AHB_OUTSTAGE_FIXED_PRIO_EN.
interface ahb_matrix_outstage_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        HSEL_SUB;
    logic [NUM_PORTS*ADDR_W-1:0] HADDR_SUB;
    logic [NUM_PORTS*2-1:0]      HTRANS_SUB;
    logic [NUM_PORTS-1:0]        HWRITE_SUB;
    logic [NUM_PORTS*3-1:0]      HSIZE_SUB;
    logic [NUM_PORTS*3-1:0]      HBURST_SUB;
    logic [NUM_PORTS*4-1:0]      HPROT_SUB;
    logic [NUM_PORTS*DATA_W-1:0] HWDATA_SUB;
    logic [NUM_PORTS-1:0]        TRANS_HOLD_SUB;
    logic                        HREADYOUT;

    logic [NUM_PORTS-1:0]        ACTIVE_SUB;
    logic                        HSEL;
    logic [ADDR_W-1:0]           HADDR;
    logic [1:0]                  HTRANS;
    logic                        HWRITE;
    logic [2:0]                  HSIZE;
    logic [2:0]                  HBURST;
    logic [3:0]                  HPROT;
    logic                        HREADY;
    logic [DATA_W-1:0]           HWDATA;

    // The output stage drives the slave, so it is the master on this bundle.
    modport master (
        input  HSEL_SUB, HADDR_SUB, HTRANS_SUB, HWRITE_SUB, HSIZE_SUB, HBURST_SUB,
               HPROT_SUB, HWDATA_SUB, TRANS_HOLD_SUB, HREADYOUT,
        output ACTIVE_SUB, HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
               HREADY, HWDATA
    );

    modport slave (
        output HSEL_SUB, HADDR_SUB, HTRANS_SUB, HWRITE_SUB, HSIZE_SUB, HBURST_SUB,
               HPROT_SUB, HWDATA_SUB, TRANS_HOLD_SUB, HREADYOUT,
        input  ACTIVE_SUB, HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
               HREADY, HWDATA
    );

endinterface

// File: rtl/ahb_matrix_rr_arbiter.sv
// Registered arbiter with burst locking; round-robin unless AHB_OUTSTAGE_FIXED_PRIO_EN
// selects fixed lowest-index priority.
module ahb_matrix_rr_arbiter
    import ahb_matrix_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = port_idx_w(NUM_PORTS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   hready_i,
    input  logic [NUM_PORTS-1:0]   hsel_i,
    input  logic [NUM_PORTS-1:0]   trans_hold_i,
    input  logic [NUM_PORTS*2-1:0] htrans_i,
    input  logic [NUM_PORTS*3-1:0] hburst_i,
    output logic [IDX_W-1:0]       grant_o,
    output logic                   noport_o
);

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] cand;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 noport_q, noport_d;
    htrans_e              cur_trans;
    logic [2:0]           cur_burst;
    logic                 lock;

    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_PORTS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    assign req = hsel_i & trans_hold_i;

    // The owner keeps the bus through the rest of a burst while it still requests.
    always_comb begin
        cur_trans = htrans_e'(htrans_i[int'(grant_q)*2 +: 2]);
        cur_burst = hburst_i[int'(grant_q)*3 +: 3];
        lock      = !noport_q && req[grant_q] &&
                    (cur_trans == HTRANS_SEQ || cur_trans == HTRANS_BUSY ||
                     (cur_trans == HTRANS_NONSEQ && cur_burst != HBURST_SINGLE));
    end

`ifdef AHB_OUTSTAGE_FIXED_PRIO_EN
    assign cand = req;
`else
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] above_ptr;

    // Ports above the last winner go first; if none request, wrap to the full set.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        above_ptr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            above_ptr[i] = (i > int'(ptr_q));
        end
        cand = (|(req & above_ptr)) ? (req & above_ptr) : req;
        ptr_d = (hready_i && !lock && |req) ? winner : ptr_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`endif

    assign winner = first_set(cand);

    always_comb begin
        grant_d  = grant_q;
        noport_d = noport_q;
        if (hready_i && !lock) begin
            if (|req) begin
                grant_d  = winner;
                noport_d = 1'b0;
            end else begin
                noport_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q  <= '0;
            noport_q <= 1'b1;
        end else begin
            grant_q  <= grant_d;
            noport_q <= noport_d;
        end
    end

    assign grant_o  = grant_q;
    assign noport_o = noport_q;

endmodule

// File: rtl/ahb_matrix_outstage_rr.sv
// AHB-Lite bus-matrix output stage: arbitrates NUM_PORTS input stages onto one slave.
// Build with AHB_OUTSTAGE_FIXED_PRIO_EN for fixed priority instead of round-robin.
module ahb_matrix_outstage_rr
    import ahb_matrix_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    ahb_matrix_outstage_rr_if.master bus
);

    localparam int IDX_W = port_idx_w(NUM_PORTS);

    logic [IDX_W-1:0]     grant;
    logic                 noport;
    logic                 hready;

    logic                 hsel;
    logic [ADDR_W-1:0]    haddr;
    logic [1:0]           htrans;
    logic                 hwrite;
    logic [2:0]           hsize;
    logic [2:0]           hburst;
    logic [3:0]           hprot;
    logic [NUM_PORTS-1:0] active;
    logic [DATA_W-1:0]    hwdata;

    logic                 trans_state_q, trans_state_d;
    logic [IDX_W-1:0]     dp_port_q, dp_port_d;
    logic                 dp_valid_q, dp_valid_d;

    ahb_matrix_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_arbiter (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .hready_i     (hready),
        .hsel_i       (bus.HSEL_SUB),
        .trans_hold_i (bus.TRANS_HOLD_SUB),
        .htrans_i     (bus.HTRANS_SUB),
        .hburst_i     (bus.HBURST_SUB),
        .grant_o      (grant),
        .noport_o     (noport)
    );

    // Address phase: pass the owner straight through, or drive IDLE with no owner.
    always_comb begin
        int g;
        g      = int'(grant);
        hsel   = 1'b0;
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = '0;
        hburst = '0;
        hprot  = '0;
        active = '0;
        if (!noport) begin
            hsel      = bus.HSEL_SUB[g];
            haddr     = bus.HADDR_SUB[g*ADDR_W +: ADDR_W];
            htrans    = bus.HTRANS_SUB[g*2 +: 2];
            hwrite    = bus.HWRITE_SUB[g];
            hsize     = bus.HSIZE_SUB[g*3 +: 3];
            hburst    = bus.HBURST_SUB[g*3 +: 3];
            hprot     = bus.HPROT_SUB[g*4 +: 4];
            active[g] = 1'b1;
        end
    end

    // Slave wait states only count once a selected transfer has entered its data phase.
    assign hready = trans_state_q ? bus.HREADYOUT : 1'b1;

    always_comb begin
        trans_state_d = trans_state_q;
        dp_port_d     = dp_port_q;
        dp_valid_d    = dp_valid_q;
        if (hready) begin
            trans_state_d = hsel;
            dp_port_d     = grant;
            dp_valid_d    = !noport;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            trans_state_q <= 1'b0;
            dp_port_q     <= '0;
            dp_valid_q    <= 1'b0;
        end else begin
            trans_state_q <= trans_state_d;
            dp_port_q     <= dp_port_d;
            dp_valid_q    <= dp_valid_d;
        end
    end

    assign hwdata = dp_valid_q ? bus.HWDATA_SUB[int'(dp_port_q)*DATA_W +: DATA_W] : '0;

    assign bus.HSEL       = hsel;
    assign bus.HADDR      = haddr;
    assign bus.HTRANS     = htrans;
    assign bus.HWRITE     = hwrite;
    assign bus.HSIZE      = hsize;
    assign bus.HBURST     = hburst;
    assign bus.HPROT      = hprot;
    assign bus.ACTIVE_SUB = active;
    assign bus.HREADY     = hready;
    assign bus.HWDATA     = hwdata;

endmodule
